// File: rtl/alu_cmd_sequencer.sv
// Issue stage for the 8-bit combinational ALU: command FIFO, registered ALU drive,
// result capture and valid/ready result port. Optional macro: ALU_DIVZERO_CHECK_EN.
module alu_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [7:0]       cmd_a,
    input  logic [7:0]       cmd_b,
    input  logic [3:0]       cmd_op,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    output logic [3:0]       alu_com,
    output logic             alu_en,
    input  logic [15:0]      alu_y,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [15:0]      res_data,
    output logic [3:0]       res_op,
    output logic             err,
    output logic [PTR_W:0]   level
);

    // state | meaning
    // IDLE  | no command in flight, waiting for FIFO to become non-empty
    // DRIVE | ALU inputs valid, alu_en high, result captured at cycle end
    // RESP  | result presented on res_*, waiting for res_ready
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [PTR_W:0] FULL_LVL = (PTR_W+1)'(DEPTH);

    state_t            state, state_nxt;
    logic [7:0]        mem_a  [DEPTH];
    logic [7:0]        mem_b  [DEPTH];
    logic [3:0]        mem_op [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    level_q;
    logic              push, pop;
    logic [15:0]       cap_data;

    assign cmd_ready = (level_q != FULL_LVL);
    assign push      = cmd_valid & cmd_ready;
    assign level     = level_q;
    assign alu_en    = (state == DRIVE);
    assign res_valid = (state == RESP);

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (level_q != '0) begin
                    pop       = 1'b1;
                    state_nxt = DRIVE;
                end
            end
            DRIVE: state_nxt = RESP;
            RESP: begin
                if (res_ready) begin
                    if (level_q != '0) begin
                        pop       = 1'b1;
                        state_nxt = DRIVE;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Storage needs no reset: entries are only read below level_q.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr]  <= cmd_a;
            mem_b[wr_ptr]  <= cmd_b;
            mem_op[wr_ptr] <= cmd_op;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   level_q <= level_q + (PTR_W+1)'(1);
                2'b01:   level_q <= level_q - (PTR_W+1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a   <= '0;
            alu_b   <= '0;
            alu_com <= '0;
        end else if (pop) begin
            alu_a   <= mem_a[rd_ptr];
            alu_b   <= mem_b[rd_ptr];
            alu_com <= mem_op[rd_ptr];
        end
    end

`ifdef ALU_DIVZERO_CHECK_EN
    logic divz;
    logic err_q;

    assign divz     = (alu_com == 4'h5) && (alu_b == 8'h00);
    assign cap_data = divz ? 16'hFFFF : alu_y;
    assign err      = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              err_q <= 1'b0;
        else if (state == DRIVE) err_q <= divz;
    end
`else
    assign cap_data = alu_y;
    assign err      = 1'b0;
`endif

    // Captured result holds through RESP and beyond until the next DRIVE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_data <= '0;
            res_op   <= '0;
        end else if (state == DRIVE) begin
            res_data <= cap_data;
            res_op   <= alu_com;
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: queue-based reference model, ALU fixture,
// per-cycle compare plus directed literal checks.
module tb_alu_cmd_sequencer;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [7:0]       cmd_a = '0;
    logic [7:0]       cmd_b = '0;
    logic [3:0]       cmd_op = '0;
    logic [7:0]       alu_a;
    logic [7:0]       alu_b;
    logic [3:0]       alu_com;
    logic             alu_en;
    logic [15:0]      alu_y;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [15:0]      res_data;
    logic [3:0]       res_op;
    logic             err;
    logic [PTR_W:0]   level;

    int n_total = 0;
    int n_pass  = 0;
    bit rand_rdy = 0;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_com(alu_com), .alu_en(alu_en),
        .alu_y(alu_y),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_op(res_op), .err(err), .level(level)
    );

    // ALU fixture
    function automatic logic [15:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] op);
        logic [15:0] wa, wb;
        wa = {8'h00, a};
        wb = {8'h00, b};
        case (op)
            4'h0: return wa + wb;
            4'h1: return wa + 16'd1;
            4'h2: return wa - wb;
            4'h3: return wa - 16'd1;
            4'h4: return wa * wb;
            4'h5: return (b == 8'h00) ? 16'h0000 : wa / wb;
            4'h6: return wa << 1;
            4'h7: return wa >> 1;
            4'h8: return {8'h00, ~a};
            4'h9: return wa & wb;
            4'hA: return wa | wb;
            4'hB: return {8'h00, ~(a & b)};
            4'hC: return {8'h00, ~(a | b)};
            4'hD: return wa ^ wb;
            4'hE: return {8'h00, ~(a ^ b)};
            default: return wa;
        endcase
    endfunction

    assign alu_y = alu_en ? alu_fn(alu_a, alu_b, alu_com) : 16'h0000;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] op;
    } cmd_t;

    // Reference model: FIFO as a queue, one command in flight, result shown after one drive cycle.
    cmd_t        m_q[$];
    cmd_t        m_cur;
    bit          m_have, m_shown, m_do_push;
    logic [7:0]  m_alu_a, m_alu_b;
    logic [3:0]  m_alu_com;
    logic [15:0] m_res_data;
    logic [3:0]  m_res_op;
    logic        m_err;
    int          cyc;
    logic [15:0] log_data[$];
    logic        log_err[$];
    int          log_cyc[$];

    task automatic model_take();
        m_cur     = m_q.pop_front();
        m_have    = 1;
        m_shown   = 0;
        m_alu_a   = m_cur.a;
        m_alu_b   = m_cur.b;
        m_alu_com = m_cur.op;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_have = 0; m_shown = 0;
            m_alu_a = 0; m_alu_b = 0; m_alu_com = 0;
            m_res_data = 0; m_res_op = 0; m_err = 0;
        end else begin
            cyc++;
            m_do_push = cmd_valid && (m_q.size() < DEPTH);
            if (!m_have) begin
                if (m_q.size() > 0) model_take();
            end else if (!m_shown) begin
                m_shown  = 1;
                m_res_op = m_cur.op;
`ifdef ALU_DIVZERO_CHECK_EN
                if (m_cur.op == 4'h5 && m_cur.b == 8'h00) begin
                    m_res_data = 16'hFFFF; m_err = 1;
                end else begin
                    m_res_data = alu_fn(m_cur.a, m_cur.b, m_cur.op); m_err = 0;
                end
`else
                m_res_data = alu_fn(m_cur.a, m_cur.b, m_cur.op);
                m_err      = 0;
`endif
            end else if (res_ready) begin
                log_data.push_back(m_res_data);
                log_err.push_back(m_err);
                log_cyc.push_back(cyc);
                if (m_q.size() > 0) model_take();
                else m_have = 0;
            end
            if (m_do_push) m_q.push_back('{a: cmd_a, b: cmd_b, op: cmd_op});
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        else n_pass++;
    endtask

    always @(negedge clk) begin
        chk("res_valid", 32'(res_valid), 32'(m_have && m_shown));
        chk("alu_en",    32'(alu_en),    32'(m_have && !m_shown));
        chk("level",     32'(level),     32'(m_q.size()));
        chk("cmd_ready", 32'(cmd_ready), 32'(m_q.size() < DEPTH));
        chk("alu_a",     32'(alu_a),     32'(m_alu_a));
        chk("alu_b",     32'(alu_b),     32'(m_alu_b));
        chk("alu_com",   32'(alu_com),   32'(m_alu_com));
        chk("res_data",  32'(res_data),  32'(m_res_data));
        chk("res_op",    32'(res_op),    32'(m_res_op));
        chk("err",       32'(err),       32'(m_err));
    end

    initial forever begin
        @(posedge clk); #1;
        if (rand_rdy) res_ready = 1'($urandom_range(0, 1));
    end

    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        bit ok;
        int n;
        n = 0;
        cmd_valid = 1; cmd_a = a; cmd_b = b; cmd_op = op;
        do begin
            ok = cmd_ready;
            @(posedge clk); #1;
            n++;
        end while (!ok && n < 300);
        cmd_valid = 0;
        chk("push_timeout", 32'(ok), 32'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((m_q.size() != 0 || m_have) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_timeout", 32'(n < 500), 32'd1);
    endtask

    task automatic wait_res_valid();
        int n;
        n = 0;
        while (!res_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("res_valid_timeout", 32'(res_valid), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        @(posedge clk); #1;
        rst_n = 1;

        // single MUL: latency and data
        res_ready = 1;
        push(8'h0F, 8'h03, 4'h4);
        @(negedge clk);
        chk("mul_en_n0", 32'(alu_en), 32'd0);
        chk("mul_valid_n0", 32'(res_valid), 32'd0);
        @(negedge clk);
        chk("mul_en_n1", 32'(alu_en), 32'd1);
        @(negedge clk);
        chk("mul_en_n2", 32'(alu_en), 32'd0);
        chk("mul_valid_n2", 32'(res_valid), 32'd1);
        chk("mul_data", 32'(res_data), 32'h002D);
        chk("mul_op", 32'(res_op), 32'd4);
        @(posedge clk); #1;
        wait_idle();

        // back-pressure and full
        res_ready = 0;
        log_data.delete(); log_err.delete(); log_cyc.delete();
        push(8'h05, 8'h06, 4'h0);
        push(8'h09, 8'h02, 4'h2);
        push(8'hFF, 8'h00, 4'h1);
        push(8'h00, 8'h00, 4'h3);
        push(8'hF0, 8'h3C, 4'hD);
        cmd_valid = 1; cmd_a = 8'h77; cmd_b = 8'h77; cmd_op = 4'h0;
        repeat (2) @(posedge clk);
        #1; cmd_valid = 0;
        @(negedge clk);
        chk("full_level", 32'(level), 32'd4);
        chk("full_cmd_ready", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1;
        res_ready = 1;
        wait_idle();
        chk("bp_count", 32'(log_data.size()), 32'd5);
        if (log_data.size() == 5) begin
            chk("bp_r0", 32'(log_data[0]), 32'h000B);
            chk("bp_r1", 32'(log_data[1]), 32'h0007);
            chk("bp_r2", 32'(log_data[2]), 32'h0100);
            chk("bp_r3", 32'(log_data[3]), 32'hFFFF);
            chk("bp_r4", 32'(log_data[4]), 32'h00CC);
            for (int i = 0; i < 4; i++)
                chk("bp_spacing", 32'(log_cyc[i+1] - log_cyc[i]), 32'd2);
        end

        // simultaneous push and pop at level 2
        res_ready = 0;
        push(8'h01, 8'h01, 4'h0);
        push(8'h02, 8'h01, 4'h0);
        push(8'h03, 8'h01, 4'h0);
        wait_res_valid();
        chk("pp_level_before", 32'(level), 32'd2);
        res_ready = 1; cmd_valid = 1; cmd_a = 8'h04; cmd_b = 8'h01; cmd_op = 4'h0;
        @(posedge clk); #1;
        res_ready = 0; cmd_valid = 0;
        @(negedge clk);
        chk("pp_level_after", 32'(level), 32'd2);
        chk("pp_alu_en", 32'(alu_en), 32'd1);
        @(posedge clk); #1;
        res_ready = 1;
        wait_idle();

        // wrap-around with random res_ready
        log_data.delete(); log_err.delete(); log_cyc.delete();
        rand_rdy = 1;
        for (int i = 0; i < 10; i++) push(8'(i), 8'h01, 4'h0);
        wait_idle();
        rand_rdy = 0;
        @(posedge clk); #1;
        res_ready = 1;
        chk("wrap_count", 32'(log_data.size()), 32'd10);
        if (log_data.size() == 10)
            for (int i = 0; i < 10; i++) chk("wrap_data", 32'(log_data[i]), 32'(i + 1));

        // divide by zero
        log_data.delete(); log_err.delete(); log_cyc.delete();
        push(8'h10, 8'h00, 4'h5);
        push(8'h10, 8'h02, 4'h5);
        wait_idle();
        chk("div_count", 32'(log_data.size()), 32'd2);
        if (log_data.size() == 2) begin
`ifdef ALU_DIVZERO_CHECK_EN
            chk("div0_data", 32'(log_data[0]), 32'hFFFF);
            chk("div0_err", 32'(log_err[0]), 32'd1);
`else
            chk("div0_data", 32'(log_data[0]), 32'h0000);
            chk("div0_err", 32'(log_err[0]), 32'd0);
`endif
            chk("div2_data", 32'(log_data[1]), 32'h0008);
            chk("div2_err", 32'(log_err[1]), 32'd0);
        end

        // random traffic
        rand_rdy = 1;
        for (int i = 0; i < 400; i++) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_a     = 8'($urandom);
            cmd_b     = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            cmd_op    = 4'($urandom);
            @(posedge clk); #1;
        end
        cmd_valid = 0;
        wait_idle();
        rand_rdy = 0;
        @(posedge clk); #1;

        // reset mid-RESP with 3 queued
        res_ready = 0;
        push(8'h11, 8'h22, 4'h0);
        push(8'h33, 8'h44, 4'h9);
        push(8'h55, 8'h66, 4'hA);
        push(8'h77, 8'h88, 4'hD);
        wait_res_valid();
        chk("mr_level", 32'(level), 32'd3);
        rst_n = 0;
        @(negedge clk);
        chk("mr_res_valid", 32'(res_valid), 32'd0);
        chk("mr_level0", 32'(level), 32'd0);
        chk("mr_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("mr_alu", 32'({alu_a, alu_b, alu_com, alu_en}), 32'd0);
        chk("mr_res", 32'({res_data, res_op, err}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1;
        res_ready = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("mr_no_stale", 32'(res_valid), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
